// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, issues word fetches and buffers
// in-order responses in a prefetch FIFO feeding decode.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [63:0] pc_q, pc_d;
  logic [63:0] tag_q, tag_d;
  cnt_t        count_q, count_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        discard_q, discard_d;
  ptr_t        rd_q, rd_d;
  ptr_t        wr_q, wr_d;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic [63:0] apc_q [DEPTH];
  logic [63:0] apc_d [DEPTH];

  logic [CW:0] credit;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic [63:0] tgt;

  assign credit = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && !redirect_valid
                          && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_q];
  assign out_pc    = apc_q[rd_q];
  assign pop       = out_valid && out_ready;

  // Responses owed to a pre-redirect stream never enter the FIFO
  assign push = imem_rsp_valid && (discard_q == '0)
                && !redirect_valid;
  assign tgt  = {redirect_pc[63:2], 2'b00};

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    count_d    = count_q;
    discard_d  = discard_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    instr_d    = instr_q;
    apc_d      = apc_q;
    inflight_d = inflight_q + cnt_t'(req_fire)
                 - cnt_t'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_d      = tgt;
      tag_d     = tgt;
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      discard_d = inflight_q - cnt_t'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 64'd4;
      if (imem_rsp_valid && (discard_q != '0))
        discard_d = discard_q - cnt_t'(1);
      if (push) begin
        instr_d[wr_q] = imem_rsp_data;
        apc_d[wr_q]   = tag_q;
        tag_d         = tag_q + 64'd4;
        wr_d          = wr_q + ptr_t'(1);
      end
      if (pop) rd_d = rd_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      instr_q    <= '{default: '0};
      apc_q      <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      instr_q    <= instr_d;
      apc_q      <= apc_d;
    end
  end

  rsp_needs_inflight: assert property (
    @(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: memory model plus an
// expected instruction-stream scoreboard checked by a monitor.
module tb_fetch_prefetch_unit;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;
  localparam int NCYC = 4000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          gen;
  } req_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t pend[$];
  exp_t expq[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int gen = 0;
  int rsp_gen = 0;
  int last_due = 0;
  int fifo_cnt = 0;
  int latmax = 1;
  bit started = 0;
  bit after_rst = 0;
  bit rf = 0;
  bit of = 0;
  logic [63:0] fetch_pc = RPC;
  logic [63:0] stream_pc = RPC;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[33:2] ^ 32'h9e37_79b9 ^ {a[15:0], a[63:48]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: every head handshake must match the next expected word
  always @(negedge clk) begin
    if (started && !reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL exp_empty: got pc %h expected none", out_pc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
      end
    end
  end

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      started = 1;
      // advance the reference model by the cycle that just ended
      if (reset) begin
        pend.delete();
        expq.delete();
        fifo_cnt = 0;
        gen++;
        fetch_pc = RPC;
        stream_pc = RPC;
        last_due = cyc;
        after_rst = 1;
      end else begin
        bit live;
        if (rf) begin
          req_t r;
          int lat;
          lat = 1 + int'($urandom % latmax);
          r.addr = fetch_pc;
          r.gen = gen;
          r.due = (cyc + lat - 1 > last_due + 1)
                  ? cyc + lat - 1 : last_due + 1;
          last_due = r.due;
          pend.push_back(r);
          fetch_pc = fetch_pc + 64'd4;
        end
        live = imem_rsp_valid && (rsp_gen == gen) && !redirect_valid;
        if (redirect_valid) begin
          gen++;
          fifo_cnt = 0;
          fetch_pc = {redirect_pc[63:2], 2'b00};
          stream_pc = fetch_pc;
          expq.delete();
        end else begin
          fifo_cnt = fifo_cnt + int'(live) - int'(of);
        end
      end
      while (expq.size() < 8) begin
        exp_t e;
        e.pc = stream_pc;
        e.instr = word(stream_pc);
        expq.push_back(e);
        stream_pc = stream_pc + 64'd4;
      end

      // choose the next cycle's stimulus by phase
      reset = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = {$urandom, $urandom};
      if (c < 3) begin
        reset = 1'b1;
      end else if (c < 200) begin
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        latmax = 1;
      end else if (c < 400) begin
        out_ready = (c >= 260);
        imem_req_ready = 1'b1;
        latmax = 2;
      end else if (c < 600) begin
        out_ready = 1'b1;
        imem_req_ready = ($urandom % 2) == 0;
        latmax = 3;
      end else begin
        int pr;
        pr = (c < 3000) ? 70 : 20;
        out_ready = ($urandom % 100) < pr;
        imem_req_ready = ($urandom % 100) < 70;
        latmax = 4;
        reset = ($urandom % 100) < ((c < 3000) ? 1 : 2);
        if (!reset) redirect_valid = ($urandom % 100) < 5;
        case ($urandom % 8)
          0: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0
                           | 64'($urandom % 16);
          1, 2, 3: redirect_pc = 64'($urandom % 4096);
          default: ;
        endcase
      end
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = word(pend[0].addr);
        rsp_gen = pend[0].gen;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
      end

      @(negedge clk);
      if (after_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", {32'h0, out_instr}, 0);
        chk("rst_pc", imem_req_addr, RPC);
        after_rst = 0;
      end
      begin
        int infl;
        bit exp_rv;
        infl = pend.size() + int'(imem_rsp_valid);
        exp_rv = !reset && !redirect_valid
                 && (fifo_cnt + infl < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("out_valid", out_valid, fifo_cnt != 0);
        if (imem_req_valid)
          chk("req_addr", imem_req_addr, fetch_pc);
      end
      rf = imem_req_valid && imem_req_ready;
      of = out_valid && out_ready;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
